// File: rtl/alu_seq.sv
// Handshaked ALU with condition codes {c,l,f,z,n}. Result is registered, with one cycle of latency except MUL, which takes WIDTH cycles.
// Optional build macro ALU_MUL_HI_EN adds a result_hi port carrying the upper product word.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic             flag_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
`ifdef ALU_MUL_HI_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_SUBC = 4'd3,
                         OP_CMP = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_XOR = 4'd7,
                         OP_NOT = 4'd8, OP_MOV = 4'd9, OP_LSH = 4'd10, OP_ASHU = 4'd11,
                         OP_LUI = 4'd12, OP_MUL = 4'd13;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         flags_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               fwr_q;
  logic [WIDTH-1:0]   hi_q;

  logic               accept;
  logic               cin;
  logic [WIDTH:0]     sum_w, dif_w;
  logic [WIDTH-1:0]   mag, alu_res;
  logic [SHW-1:0]     sh;
  logic               sh_big;
  logic [4:0]         alu_flg;
  logic [2*WIDTH-1:0] acc_d;

  assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
`ifdef ALU_MUL_HI_EN
  assign result_hi = hi_q;
`endif

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    cin     = flags_q[4] && (op == OP_ADDC || op == OP_SUBC);
    sum_w   = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, cin};
    dif_w   = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, cin};
    // src is a signed shift amount; its magnitude picks distance, its sign picks direction
    mag     = src[WIDTH-1] ? -src : src;
    sh_big  = (mag >= WIDTH'(WIDTH));
    sh      = mag[SHW-1:0];
    alu_res = '0;
    alu_flg = flags_q;
    case (op)
      OP_ADD, OP_ADDC: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_flg = {sum_w[WIDTH], flags_q[3],
                   (dst[WIDTH-1] == src[WIDTH-1]) && (sum_w[WIDTH-1] != dst[WIDTH-1]),
                   ~|sum_w[WIDTH-1:0], sum_w[WIDTH-1]};
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_flg = {dif_w[WIDTH], dst < src,
                   (dst[WIDTH-1] != src[WIDTH-1]) && (dif_w[WIDTH-1] != dst[WIDTH-1]),
                   ~|dif_w[WIDTH-1:0], $signed(dst) < $signed(src)};
      end
      OP_AND: begin alu_res = dst & src; alu_flg[1] = ~|(dst & src); end
      OP_OR:  begin alu_res = dst | src; alu_flg[1] = ~|(dst | src); end
      OP_XOR: begin alu_res = dst ^ src; alu_flg[1] = ~|(dst ^ src); end
      OP_NOT: begin alu_res = ~dst;      alu_flg[1] = ~|(~dst);      end
      OP_MOV: alu_res = src;
      OP_LSH: begin
        if (sh_big)            alu_res = '0;
        else if (src[WIDTH-1]) alu_res = dst >> sh;
        else                   alu_res = dst << sh;
      end
      OP_ASHU: begin
        if (!src[WIDTH-1])     alu_res = sh_big ? '0 : dst << sh;
        else if (sh_big)       alu_res = {WIDTH{dst[WIDTH-1]}};
        else                   alu_res = $signed(dst) >>> sh;
      end
      OP_LUI: alu_res = {src[7:0], {(WIDTH-8){1'b0}}};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      fwr_q       <= 1'b0;
      hi_q        <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q  <= S_MUL;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, dst};
              mplier_q <= src;
              fwr_q    <= flag_wr;
            end else begin
              result_q    <= alu_res;
              hi_q        <= '0;
              out_valid_q <= 1'b1;
              if (flag_wr) flags_q <= alu_flg;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            state_q     <= S_IDLE;
            result_q    <= acc_d[WIDTH-1:0];
            hi_q        <= acc_d[2*WIDTH-1:WIDTH];
            out_valid_q <= 1'b1;
            if (fwr_q) begin
              flags_q[1] <= ~|acc_d[WIDTH-1:0];
`ifdef ALU_MUL_HI_EN
              flags_q[4] <= |acc_d[2*WIDTH-1:WIDTH];
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the combinational 16-bit datapath ALU. It accepts one operation per transaction and returns a registered result. It holds the processor condition-code register {c,l,f,z,n} internally and updates it on completion. Multiply runs as an iterative shift-add over WIDTH cycles. It sits between register-file read and writeback in the multi-cycle core.

Parameters:
WIDTH, 16, datapath width in bits; legal range 16..64.
SHW, $clog2(WIDTH), width of the shift-magnitude field; derived, not overridden.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  ALU can accept an operation this cycle
op  input  4  0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 MOV, 10 LSH, 11 ASHU, 12 LUI, 13 MUL, 14/15 reserved
dst  input  WIDTH  first operand
src  input  WIDTH  second operand or immediate (already extended)
flag_wr  input  1  operation may update the flags
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
result  output  WIDTH  registered result
flags  output  5  condition-code register {c,l,f,z,n}

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0; result=0; flags=0; in_ready=0 while reset is asserted, then 1. An in-flight MUL is aborted and its result discarded.
- Accept: in_valid & in_ready. The ALU latches op, dst, src, flag_wr, and the current flags.c (carry-in).
- in_ready = (state==IDLE) & (!out_valid | out_ready). Back-to-back issue is allowed when the result is consumed in the same cycle.
- States:
  - IDLE: on accept of a non-MUL op, go to IDLE and set out_valid=1 at the next edge (latency 1). On accept of MUL, go to MUL with counter=0.
  - MUL: one multiplier bit per cycle, LSB first, using a 2*WIDTH accumulator. At counter==WIDTH-1, write result and set out_valid at the next edge, then go to IDLE. Latency from accept to out_valid is WIDTH cycles.
- out_valid stays high, and result stays stable, until out_ready. No result is dropped.
- Flags update in the same edge that raises out_valid, and only if flag_wr was latched. They are never changed by a reserved op or by a MOV, LSH, ASHU or LUI op.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: dst+src. ADDC: dst+src+c.
  - SUB and CMP: dst-src. SUBC: dst-src-c.
- Flags for ADD/ADDC:
  - c = carry out; f = signed overflow; z = (result==0); n = result[WIDTH-1]; l unchanged.
- Flags for SUB/SUBC/CMP:
  - c = borrow; l = (dst<src) unsigned; n = (dst<src) signed; f = signed overflow; z = (result==0).
  - CMP still drives result; writeback suppression is the decoder's job.
- AND, OR, XOR, NOT(~dst): only z is updated; other flags unchanged.
- MOV: result=src.
- LUI: result = src[7:0] << (WIDTH-8).
- LSH and ASHU: src is read as a signed shift amount.
  - src>=0: shift dst left by src.
  - src<0: shift dst right by -src. LSH fills with zeros; ASHU fills with dst[WIDTH-1].
  - If the magnitude is >=WIDTH: left and logical-right shifts give 0; arithmetic right gives all dst[WIDTH-1].
- MUL: result = low WIDTH bits of the unsigned product; z = (low word==0); other flags as set by the optional feature.
- Reserved ops: result=0, latency 1, flags unchanged.
- reset asserted while out_valid=1: the result is lost and out_valid drops immediately.

Optional Feature:
ALU_MUL_HI_EN
- Defined: adds port result_hi (output, WIDTH bits) carrying the upper product word, registered alongside result. For MUL, c = (upper word != 0). result_hi=0 for all non-MUL ops and after reset.
- Undefined: no result_hi port. MUL updates only z, and c is unchanged.

Test Plan:
All scenarios use WIDTH=16.
- ADD, flag_wr=1, dst=16'hFFFF, src=16'h0001 -> one cycle later out_valid=1, result=16'h0000, flags c=1 z=1 f=0 n=0.
- SUB, dst=16'h8000, src=16'h0001 -> result=16'h7FFF, f=1, l=0, n=1 (signed -32768<1), c=0. CMP with dst=3, src=5 -> l=1, n=1, c=1, z=0.
- LSH, dst=16'h8001: src=16'hFFFF gives 16'h4000; src=16'h0001 gives 16'h0002. ASHU, dst=16'h8000, src=16'hFFF0 (-16) gives 16'hFFFF.
- MUL, dst=16'h0100, src=16'h0300 -> in_ready=0 for 16 cycles, out_valid on cycle 16, result=16'h0000, z=1. With ALU_MUL_HI_EN: result_hi=16'h0003, c=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD -> result held and in_ready=0. Raise out_ready with a new in_valid -> accepted in the same cycle, no bubble.
- Assert reset at MUL cycle 7 -> out_valid=0 and flags=0 immediately. After release, an ADDC 1+1 gives result 2 (carry-in cleared).
